// File: rtl/act_codec_pkg.sv
// Shared definitions for the mixed-precision activation codec (quantizer and decoder).
// Frame layout constants, Q16.16 saturation limits and the decoder state type.
package act_codec_pkg;

    localparam int INPUT_SIZE = 128;
    localparam int M          = 4;
    localparam int CODE_W     = 8;
    localparam int DATA_W     = 32;
    localparam int SCALE_W    = 16;
    localparam int CNT_W      = 8;
    localparam int IDX_W      = $clog2(INPUT_SIZE);

    // Code x Q8.8 scale yields Q16.8; this many zero bits lift it to Q16.16
    localparam int FRAC_SHIFT = 8;

    localparam logic [DATA_W-1:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

    localparam int HDR_SCALE_LSB = 16;
    localparam int HDR_CNT_LSB   = 0;
    localparam int CODE_FLAG_BIT = 8;
    localparam int CODE_LSB      = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CODE  = 2'd1,
        ST_VALUE = 2'd2
    } dec_state_e;

    // Collapse an outlier to the rail matching its sign; zero stays zero
    function automatic logic [DATA_W-1:0] sat_outlier(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v[DATA_W-1]) begin
            r = INT_MIN;
        end else if (v != {DATA_W{1'b0}}) begin
            r = INT_MAX;
        end else begin
            r = {DATA_W{1'b0}};
        end
        return r;
    endfunction

endpackage

// File: rtl/code_scaler.sv
// Combinational dequantiser: signed int8 code times unsigned Q8.8 scale, result in Q16.16.
module code_scaler
    import act_codec_pkg::*;
(
    input  logic signed [CODE_W-1:0]  code_i,
    input  logic        [SCALE_W-1:0] scale_i,
    output logic        [DATA_W-1:0]  value_o
);

    logic signed [DATA_W-1:0] prod_s;

    // Product magnitude stays below 2^23, so a full-width signed multiply is exact
    assign prod_s  = DATA_W'(code_i) * DATA_W'($signed({1'b0, scale_i}));
    assign value_o = prod_s <<< FRAC_SHIFT;

endmodule

// File: rtl/act_dequant_decoder.sv
// Rebuilds a dense Q16.16 activation vector from an int8 + outlier encoded frame,
// one element per cycle through a single-entry output register.
module act_dequant_decoder
    import act_codec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_is_outlier,
    output logic              out_last,
    output logic              sat_mode,
    output logic              err_count
);

    dec_state_e          state_q, state_d;
    logic [SCALE_W-1:0]  scale_q, scale_d;
    logic [CNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [IDX_W-1:0]    elem_idx_q, elem_idx_d;
    logic [CNT_W-1:0]    flag_cnt_q, flag_cnt_d;
    logic                sat_q, sat_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_outl_q, out_outl_d;
    logic                out_last_q, out_last_d;
    logic                out_err_q, out_err_d;

    logic                in_fire_s;
    logic                out_fire_s;
    logic                is_last_s;
    logic                emit_s;
    logic                emit_outl_s;
    logic [DATA_W-1:0]   emit_data_s;
    logic [DATA_W-1:0]   scaled_s;

    code_scaler u_scaler (
        .code_i  (in_data[CODE_LSB +: CODE_W]),
        .scale_i (scale_q),
        .value_o (scaled_s)
    );

    assign in_ready   = (state_q == ST_IDLE) || !out_valid_q || out_ready;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid_q && out_ready;
    assign is_last_s  = (elem_idx_q == IDX_W'(INPUT_SIZE - 1));

    // Frame FSM, counters and output-register next state
    always_comb begin
        state_d     = state_q;
        scale_d     = scale_q;
        hdr_cnt_d   = hdr_cnt_q;
        elem_idx_d  = elem_idx_q;
        flag_cnt_d  = flag_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_outl_d  = out_outl_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        emit_s      = 1'b0;
        emit_outl_s = 1'b0;
        emit_data_s = {DATA_W{1'b0}};

        if (out_fire_s && out_last_q) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) begin
                    scale_d    = in_data[HDR_SCALE_LSB +: SCALE_W];
                    hdr_cnt_d  = in_data[HDR_CNT_LSB +: CNT_W];
                    elem_idx_d = {IDX_W{1'b0}};
                    flag_cnt_d = {CNT_W{1'b0}};
                    sat_d      = (in_data[HDR_CNT_LSB +: CNT_W] > CNT_W'(M));
                    state_d    = ST_CODE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CODE: begin
                if (in_fire_s) begin
                    if (in_data[CODE_FLAG_BIT]) begin
                        flag_cnt_d = flag_cnt_q + CNT_W'(1);
                        state_d    = ST_VALUE;
                    end else begin
                        emit_s      = 1'b1;
                        emit_data_s = scaled_s;
                    end
                end else begin
                    state_d = ST_CODE;
                end
            end
            ST_VALUE: begin
                if (in_fire_s) begin
                    emit_s      = 1'b1;
                    emit_outl_s = 1'b1;
                    emit_data_s = sat_q ? sat_outlier(in_data) : in_data;
                    state_d     = ST_CODE;
                end else begin
                    state_d = ST_VALUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (emit_s) begin
            elem_idx_d  = elem_idx_q + IDX_W'(1);
            state_d     = is_last_s ? ST_IDLE : state_d;
            out_valid_d = 1'b1;
            out_data_d  = emit_data_s;
            out_outl_d  = emit_outl_s;
            out_last_d  = is_last_s;
            out_err_d   = is_last_s && (flag_cnt_d != hdr_cnt_q);
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
            out_data_d  = {DATA_W{1'b0}};
            out_outl_d  = 1'b0;
            out_last_d  = 1'b0;
            out_err_d   = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            scale_q     <= {SCALE_W{1'b0}};
            hdr_cnt_q   <= {CNT_W{1'b0}};
            elem_idx_q  <= {IDX_W{1'b0}};
            flag_cnt_q  <= {CNT_W{1'b0}};
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_outl_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            scale_q     <= scale_d;
            hdr_cnt_q   <= hdr_cnt_d;
            elem_idx_q  <= elem_idx_d;
            flag_cnt_q  <= flag_cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_outl_q  <= out_outl_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_is_outlier = out_outl_q;
    assign out_last       = out_last_q;
    assign sat_mode       = sat_q;
    assign err_count      = out_err_q;

endmodule

// File: tb/tb_act_dequant_decoder.sv
// Randomised bench for act_dequant_decoder: frames are described element by element and
// the expected output stream is derived arithmetically from the frame description.
module tb_act_dequant_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_is_outlier;
    logic        out_last;
    logic        sat_mode;
    logic        err_count;

    int errors = 0;
    int checks = 0;

    logic signed [7:0] f_code [128];
    bit                f_flag [128];
    logic [31:0]       f_val  [128];
    logic [15:0]       f_scale;
    logic [7:0]        f_hdr;
    logic [31:0]       first_obs;

    act_dequant_decoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_is_outlier (out_is_outlier),
        .out_last       (out_last),
        .sat_mode       (sat_mode),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic clear_frame(input logic [15:0] scale, input logic [7:0] hdr, input logic signed [7:0] code);
        f_scale = scale;
        f_hdr   = hdr;
        for (int i = 0; i < 128; i++) begin
            f_code[i] = code;
            f_flag[i] = 1'b0;
            f_val[i]  = 32'h0;
        end
    endtask

    // Drives one frame and checks every delivered element; abort_at >= 0 asserts reset after that element
    task automatic run_frame(input bit rnd, input int abort_at);
        logic [31:0] beats[$];
        logic [31:0] e_data[$];
        bit          e_outl[$];
        bit          e_last[$];
        bit          e_err[$];
        int          nflag = 0;
        bit          sat;
        int          idx = 0;
        int          cyc = 0;
        int          first_c = -1;
        int          last_c = -1;
        bit          stalled = 1'b0;
        bit          aborted = 1'b0;
        logic [31:0] hold_d;
        bit          hold_o, hold_l, hold_e;
        longint      p;

        for (int i = 0; i < 128; i++) if (f_flag[i]) nflag++;
        sat = (f_hdr > 8'd4);
        beats.push_back({f_scale, 8'h00, f_hdr});
        for (int i = 0; i < 128; i++) begin
            beats.push_back({23'($urandom), f_flag[i], f_code[i]});
            if (f_flag[i]) begin
                beats.push_back(f_val[i]);
                if (!sat)                    e_data.push_back(f_val[i]);
                else if ($signed(f_val[i]) > 0) e_data.push_back(32'h7FFF_FFFF);
                else if ($signed(f_val[i]) < 0) e_data.push_back(32'h8000_0000);
                else                         e_data.push_back(32'h0);
            end else begin
                p = longint'(f_code[i]) * longint'(f_scale) * 256;
                e_data.push_back(p[31:0]);
            end
            e_outl.push_back(f_flag[i]);
            e_last.push_back(i == 127);
            e_err.push_back((i == 127) && (nflag != int'(f_hdr)));
        end

        while (e_data.size() > 0 && cyc < 20000) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hold_d || out_is_outlier !== hold_o ||
                    out_last !== hold_l || err_count !== hold_e) begin
                    errors++;
                    $display("FAIL stall_hold elem %0d: got v=%b d=%h o=%b l=%b e=%b, want v=1 d=%h o=%b l=%b e=%b",
                             idx, out_valid, out_data, out_is_outlier, out_last, err_count,
                             hold_d, hold_o, hold_l, hold_e);
                end
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (beats.size() > 0 && (!rnd || $urandom_range(0, 4) != 0)) begin
                in_valid = 1'b1;
                in_data  = beats[0];
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== e_data[0] || out_is_outlier !== e_outl[0] || out_last !== e_last[0] ||
                    err_count !== e_err[0] || sat_mode !== sat) begin
                    errors++;
                    $display("FAIL elem %0d: got d=%h o=%b l=%b e=%b s=%b, want d=%h o=%b l=%b e=%b s=%b",
                             idx, out_data, out_is_outlier, out_last, err_count, sat_mode,
                             e_data[0], e_outl[0], e_last[0], e_err[0], sat);
                end
                if (idx == 0) begin
                    first_obs = out_data;
                    first_c   = cyc;
                end
                last_c = cyc;
                void'(e_data.pop_front());
                void'(e_outl.pop_front());
                void'(e_last.pop_front());
                void'(e_err.pop_front());
                if (idx == abort_at) begin
                    aborted = 1'b1;
                end
                idx++;
            end
            stalled = out_valid && !out_ready;
            hold_d  = out_data;
            hold_o  = out_is_outlier;
            hold_l  = out_last;
            hold_e  = err_count;
            if (in_valid && in_ready) void'(beats.pop_front());
            cyc++;
            if (aborted) break;
        end

        if (aborted) begin
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || sat_mode !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0) begin
                errors++;
                $display("FAIL async_reset: got v=%b s=%b l=%b d=%h, want all zero",
                         out_valid, sat_mode, out_last, out_data);
            end
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            checks++;
            if (e_data.size() != 0) begin
                errors++;
                $display("FAIL frame_timeout: got %0d elements, want 128", idx);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (sat_mode !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_frame: got sat=%b v=%b, want sat=0 v=0", sat_mode, out_valid);
            end
            if (!rnd && nflag == 0) begin
                checks++;
                if (last_c - first_c != 127) begin
                    errors++;
                    $display("FAIL throughput: got span %0d cycles, want 127", last_c - first_c);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_is_outlier !== 1'b0 ||
            out_last !== 1'b0 || sat_mode !== 1'b0 || err_count !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b d=%h o=%b l=%b s=%b e=%b, want all zero",
                     out_valid, out_data, out_is_outlier, out_last, sat_mode, err_count);
        end
    endtask

    task automatic test_unity_scale();
        clear_frame(16'h0100, 8'd0, 8'sd5);
        run_frame(1'b0, -1);
        checks++;
        if (first_obs !== 32'h0005_0000) begin
            errors++;
            $display("FAIL unity_value: got %h, want 00050000", first_obs);
        end
    endtask

    task automatic test_scaler_corners();
        clear_frame(16'h0180, 8'd0, -8'sd3);
        run_frame(1'b1, -1);
        checks++;
        if (first_obs !== 32'hFFFB_8000) begin
            errors++;
            $display("FAIL scale_neg3_1p5: got %h, want fffb8000", first_obs);
        end
        clear_frame(16'hFFFF, 8'd0, -8'sd128);
        run_frame(1'b0, -1);
        checks++;
        if (first_obs !== 32'h8000_8000) begin
            errors++;
            $display("FAIL scale_min_max: got %h, want 80008000", first_obs);
        end
    endtask

    task automatic test_outliers();
        clear_frame(16'h0100, 8'd2, 8'sd7);
        f_flag[10]  = 1'b1;
        f_val[10]   = 32'h00C8_0000;
        f_flag[127] = 1'b1;
        f_val[127]  = 32'hFF38_0000;
        run_frame(1'b0, -1);
    endtask

    task automatic test_saturation();
        int          pos[6] = '{3, 20, 45, 77, 100, 126};
        logic [31:0] val[6] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h7F00_0000, 32'h8000_0001, 32'hFFFF_FFFF};
        clear_frame(16'h0040, 8'd6, -8'sd9);
        for (int i = 0; i < 6; i++) begin
            f_flag[pos[i]] = 1'b1;
            f_val[pos[i]]  = val[i];
        end
        run_frame(1'b1, -1);
    endtask

    task automatic test_count_mismatch();
        clear_frame(16'h0200, 8'd3, 8'sd1);
        f_flag[30] = 1'b1;
        f_val[30]  = 32'h1234_5678;
        f_flag[90] = 1'b1;
        f_val[90]  = 32'hEDCB_A988;
        run_frame(1'b1, -1);
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            clear_frame(16'($urandom), 8'd0, 8'sd0);
            for (int i = 0; i < 128; i++) begin
                f_code[i] = 8'($urandom);
                f_flag[i] = ($urandom_range(0, 15) == 0);
                f_val[i]  = $urandom;
                if (f_flag[i]) n++;
            end
            f_hdr = 8'(n);
            run_frame(1'b1, -1);
        end
    endtask

    task automatic test_reset_midframe();
        clear_frame(16'h0100, 8'd5, 8'sd2);
        run_frame(1'b0, 60);
        clear_frame(16'h0080, 8'd1, -8'sd4);
        f_flag[0] = 1'b1;
        f_val[0]  = 32'hABCD_0000;
        run_frame(1'b1, -1);
        checks++;
        if (first_obs !== 32'hABCD_0000) begin
            errors++;
            $display("FAIL restart_elem0: got %h, want abcd0000", first_obs);
        end
    endtask

    initial begin
        test_reset();
        test_unity_scale();
        test_scaler_corners();
        test_outliers();
        test_saturation();
        test_count_mismatch();
        test_random_frames();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
